// File: rtl/free_list_param.sv
// Physical-register free list for rename. A circular list of preg numbers:
// allocation pops up to WAY entries from the head, all-or-nothing. Retire
// pushes up to WAY entries at the tail. Head can be rolled back to a
// checkpoint on flush. A free group that would overfill the list is dropped
// and raises a sticky error.
module free_list_param #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 16,
  parameter int WAY       = 4,
  localparam int PW       = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [PW:0]       flush_ptr,
  input  logic [WAY-1:0]    alloc_req,
  output logic [WAY*PW-1:0] alloc_preg,
  output logic              alloc_ok,
  input  logic [WAY-1:0]    free_vld,
  input  logic [WAY*PW-1:0] free_preg,
  output logic [PW:0]       alloc_ptr,
  output logic [PW:0]       free_cnt,
  output logic              list_empty,
  output logic              overflow_err
);

  logic [PW-1:0]            list [NUM_PREGS];
  logic [PW:0]              head, tail;
  logic [PW:0]              a_cnt, f_cnt;
  logic [WAY-1:0][PW-1:0]   rd_idx, wr_idx;
  logic                     ovf;

  // Running prefix counts compact the sparse request/valid bits onto
  // consecutive list slots. Index math is PW bits wide, so it wraps for free.
  always_comb begin
    a_cnt = '0;
    f_cnt = '0;
    for (int k = 0; k < WAY; k++) begin
      rd_idx[k] = head[PW-1:0] + a_cnt[PW-1:0];
      wr_idx[k] = tail[PW-1:0] + f_cnt[PW-1:0];
      a_cnt     = a_cnt + (PW+1)'(alloc_req[k]);
      f_cnt     = f_cnt + (PW+1)'(free_vld[k]);
    end
  end

  // The wrap bit makes tail-head exact even when the list is completely full.
  assign free_cnt   = tail - head;
  assign list_empty = (free_cnt == '0);
  assign alloc_ptr  = head;
  assign alloc_ok   = (a_cnt != '0) && (a_cnt <= free_cnt) && !stall && !flush;
  // The extra bit keeps a full list plus a free group from wrapping the sum.
  assign ovf        = ({1'b0, free_cnt} + {1'b0, f_cnt}) > (PW+2)'(NUM_PREGS);

  // Grant mux: a slot sees its preg only when the whole group is granted.
  always_comb begin
    alloc_preg = '0;
    for (int k = 0; k < WAY; k++)
      if (alloc_ok && alloc_req[k]) alloc_preg[k*PW +: PW] = list[rd_idx[k]];
  end

  // Head and tail pointers, plus the sticky overflow flag. Stall freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= (PW+1)'(NUM_AREGS);
      tail         <= (PW+1)'(NUM_PREGS);
      overflow_err <= 1'b0;
    end else if (!stall) begin
      if (flush)         head <= flush_ptr;
      else if (alloc_ok) head <= head + a_cnt;
      if (ovf)           overflow_err <= 1'b1;
      else               tail <= tail + f_cnt;
    end
  end

  // List storage: it starts as an identity map, and frees are written in at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) list[i] <= PW'(i);
    end else if (!stall && !ovf) begin
      for (int k = 0; k < WAY; k++)
        if (free_vld[k]) list[wr_idx[k]] <= free_preg[k*PW +: PW];
    end
  end

endmodule

// File: tb/tb_free_list_param.sv
// Bench for free_list_param. A reference model keeps unbounded integer
// head/tail counters over a plain array. Directed steps come first, then a
// randomized run.
module tb_free_list_param;
  localparam int NP = 64, NA = 16, W = 4, PW = 6;

  logic            clk = 1'b0, rst_n = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [PW:0]     flush_ptr = '0;
  logic [W-1:0]    alloc_req = '0, free_vld = '0;
  logic [W*PW-1:0] free_preg = '0;
  logic [W*PW-1:0] alloc_preg;
  logic            alloc_ok, list_empty, overflow_err;
  logic [PW:0]     alloc_ptr, free_cnt;

  free_list_param #(.NUM_PREGS(NP), .NUM_AREGS(NA), .WAY(W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_ptr(flush_ptr),
    .alloc_req(alloc_req), .alloc_preg(alloc_preg), .alloc_ok(alloc_ok),
    .free_vld(free_vld), .free_preg(free_preg), .alloc_ptr(alloc_ptr),
    .free_cnt(free_cnt), .list_empty(list_empty), .overflow_err(overflow_err));

  always #5 clk = ~clk;

  int m_mem[NP];
  int m_head, m_tail, m_fp;
  bit m_err;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W*PW-1:0] pk(input int a, b, c, d);
    return {PW'(d), PW'(c), PW'(b), PW'(a)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_mem[i] = i;
    m_head = NA; m_tail = NP; m_err = 0;
  endtask

  // Compare every output against the model; called at the falling edge.
  task automatic check_model();
    int fc, n, j, e;
    bit ok;
    fc = m_tail - m_head;
    n  = $countones(alloc_req);
    ok = (n != 0) && (n <= fc) && !stall && !flush;
    chk("alloc_ok", alloc_ok, ok);
    chk("free_cnt", free_cnt, fc % 128);
    chk("list_empty", list_empty, fc == 0);
    chk("alloc_ptr", alloc_ptr, m_head % 128);
    chk("overflow_err", overflow_err, m_err);
    j = 0;
    for (int k = 0; k < W; k++) begin
      e = 0;
      if (ok && alloc_req[k]) begin e = m_mem[(m_head + j) % NP]; j++; end
      chk("alloc_preg", alloc_preg[k*PW +: PW], e);
    end
  endtask

  task automatic drive(input logic [W-1:0] ar, input logic [W-1:0] fv,
                       input logic [W*PW-1:0] fp, input bit fl, input int fpt, input bit st);
    alloc_req = ar; free_vld = fv; free_preg = fp; flush = fl; stall = st;
    m_fp = fpt; flush_ptr = (PW+1)'(fpt % 128);
  endtask

  task automatic cyc(input logic [W-1:0] ar, input logic [W-1:0] fv,
                     input logic [W*PW-1:0] fp, input bit fl, input int fpt, input bit st);
    drive(ar, fv, fp, fl, fpt, st);
    @(negedge clk);
    check_model();
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic tick();
    int fc, n, m, j;
    bit ok;
    @(posedge clk);
    fc = m_tail - m_head;
    n  = $countones(alloc_req);
    m  = $countones(free_vld);
    ok = (n != 0) && (n <= fc) && !stall && !flush;
    if (!stall) begin
      if (fc + m > NP) m_err = 1;
      else begin
        j = 0;
        for (int k = 0; k < W; k++)
          if (free_vld[k]) begin m_mem[(m_tail + j) % NP] = free_preg[k*PW +: PW]; j++; end
        m_tail += m;
      end
      if (flush)   m_head = m_fp;
      else if (ok) m_head += n;
    end
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive('0, '0, '0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_alloc_ptr", alloc_ptr, NA);
    chk("rst_free_cnt", free_cnt, NP - NA);
    chk("rst_overflow", overflow_err, 0);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int fc, m, r;
    logic [W-1:0] ar, fv;
    bit fl, st;
    reset_dut();

    // Reset state and the first 4-wide grant.
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("reset_ok", alloc_ok, 0);
    chk("reset_preg", alloc_preg, 0);
    tick();
    cyc(4'b1111, '0, '0, 0, 0, 0);
    chk("g_ok", alloc_ok, 1);
    chk("g_p0", alloc_preg[5:0], 16);
    chk("g_p1", alloc_preg[11:6], 17);
    chk("g_p2", alloc_preg[17:12], 18);
    chk("g_p3", alloc_preg[23:18], 19);
    tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("g_ptr", alloc_ptr, 20);
    chk("g_cnt", free_cnt, 44);
    tick();

    // Sparse request: the grants are compacted.
    cyc(4'b1010, '0, '0, 0, 0, 0);
    chk("sp_s0", alloc_preg[5:0], 0);
    chk("sp_s1", alloc_preg[11:6], 20);
    chk("sp_s2", alloc_preg[17:12], 0);
    chk("sp_s3", alloc_preg[23:18], 21);
    tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("sp_ptr", alloc_ptr, 22);
    tick();

    // Drain down to two entries, check that a partial grant is refused, then empty the list.
    repeat (10) begin cyc(4'b1111, '0, '0, 0, 0, 0); tick(); end
    cyc(4'b0111, '0, '0, 0, 0, 0);
    chk("short_ok", alloc_ok, 0);
    chk("short_preg", alloc_preg, 0);
    chk("short_cnt", free_cnt, 2);
    tick();
    cyc(4'b0011, '0, '0, 0, 0, 0);
    chk("last_ok", alloc_ok, 1);
    tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("empty", list_empty, 1);
    chk("empty_ptr", alloc_ptr, 64);
    tick();

    // Wrap-around: move the tail to index 62, free 40..43 across the wrap, then allocate them back.
    cyc(4'b0000, 4'b0011, pk(1, 2, 0, 0), 0, 0, 0); tick();
    cyc(4'b0000, 4'b1111, pk(3, 4, 5, 6), 0, 0, 0); tick();
    for (int i = 0; i < 14; i++) begin
      cyc(4'b1111, 4'b1111, pk(20 + i, 21 + i, 22 + i, 23 + i), 0, 0, 0); tick();
    end
    cyc(4'b0000, 4'b1111, pk(40, 41, 42, 43), 0, 0, 0); tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("wrap_cnt", free_cnt, 10);
    tick();
    cyc(4'b1111, '0, '0, 0, 0, 0); tick();
    cyc(4'b0011, '0, '0, 0, 0, 0); tick();
    cyc(4'b1111, '0, '0, 0, 0, 0);
    chk("wrap_p0", alloc_preg[5:0], 40);
    chk("wrap_p1", alloc_preg[11:6], 41);
    chk("wrap_p2", alloc_preg[17:12], 42);
    chk("wrap_p3", alloc_preg[23:18], 43);
    tick();

    // Checkpoint at 20, allocate 8, then flush back while freeing preg 5 in the same cycle.
    reset_dut();
    cyc(4'b1111, '0, '0, 0, 0, 0); tick();
    cyc(4'b1111, '0, '0, 0, 0, 0); tick();
    cyc(4'b1111, '0, '0, 0, 0, 0); tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("pre_fl_cnt", free_cnt, 36);
    tick();
    cyc(4'b1111, 4'b0001, pk(5, 0, 0, 0), 1, 20, 0);
    chk("fl_ok", alloc_ok, 0);
    tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("fl_ptr", alloc_ptr, 20);
    chk("fl_cnt", free_cnt, 45);
    tick();
    cyc(4'b0001, '0, '0, 0, 0, 0);
    chk("fl_realloc", alloc_preg[5:0], 20);
    tick();

    // Overflow: from a free count of 62, a group of four frees is dropped. After that, stall holds all state.
    reset_dut();
    cyc(4'b0000, 4'b1111, pk(1, 2, 3, 4), 0, 0, 0); tick();
    cyc(4'b0000, 4'b1111, pk(5, 6, 7, 8), 0, 0, 0); tick();
    cyc(4'b0000, 4'b1111, pk(9, 10, 11, 12), 0, 0, 0); tick();
    cyc(4'b0000, 4'b0011, pk(13, 14, 0, 0), 0, 0, 0); tick();
    cyc(4'b0000, 4'b1111, pk(20, 21, 22, 23), 0, 0, 0);
    chk("ovf_pre", free_cnt, 62);
    tick();
    cyc(4'b0000, '0, '0, 0, 0, 0);
    chk("ovf_err", overflow_err, 1);
    chk("ovf_cnt", free_cnt, 62);
    tick();
    repeat (3) begin
      cyc(4'b1111, 4'b0001, pk(9, 0, 0, 0), 1, 30, 1);
      chk("stall_ok", alloc_ok, 0);
      chk("stall_ptr", alloc_ptr, 16);
      chk("stall_cnt", free_cnt, 62);
      tick();
    end
    cyc(4'b1111, '0, '0, 0, 0, 0);
    chk("post_stall_err", overflow_err, 1);
    chk("post_stall_p0", alloc_preg[5:0], 16);
    tick();

    // Randomized run, checked every cycle against the model.
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      ar = W'($urandom);
      fv = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      fc = m_tail - m_head;
      if (fc + $countones(fv) > NP && $urandom_range(0, 9) != 0) fv = '0;
      m  = (fc + $countones(fv) > NP) ? 0 : $countones(fv);
      fl = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 9) == 0);
      r  = $urandom_range(0, NP - fc - m);
      if (r > m_head) r = m_head;
      cyc(ar, fv, W*PW'($urandom), fl, m_head - r, st);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
